// File: rtl/spi_target_pkg.sv
// Shared constants and state encoding for the SPI target block.
// Mode 0 only: data sampled on SCK rise, changed on SCK fall, MSB first.
package spi_target_pkg;

  localparam int SPI_CPOL            = 0;
  localparam int SPI_CPHA            = 0;
  localparam bit SPI_MSB_FIRST       = 1'b1;
  localparam int WIDTH_DEFAULT       = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/spi_target_sync_edge.sv
// Pad-input synchronizer with one history flop and registered rise/fall strobes.
// The level output is the history flop, so it lines up with the strobes.
module sync_edge
  import spi_target_pkg::*;
#(
  parameter int   STAGES     = SYNC_STAGES_DEFAULT,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              hist_reg;
  logic              rise_reg;
  logic              fall_reg;
  logic              cur;

  assign cur = sync_reg[STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_reg <= {STAGES{IDLE_LEVEL}};
      hist_reg <= IDLE_LEVEL;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      hist_reg <= cur;
      rise_reg <= cur & ~hist_reg;
      fall_reg <= ~cur & hist_reg;
    end
  end

  assign level = hist_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled pads, byte-parallel receive strobe and a
// one-deep transmit holding register with valid/ready handshake.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_sck,
  input  logic             in_cs_n,
  input  logic             in_mosi,
  output logic             out_miso,
  output logic             out_miso_oe,
  output logic [WIDTH-1:0] out_rx_data,
  output logic             out_rx_valid,
  input  logic [WIDTH-1:0] in_tx_data,
  input  logic             in_tx_valid,
  output logic             out_tx_ready,
  output logic             out_underrun,
  output logic             out_busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic unused_sync;

  sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sck (
    .clock(clock), .reset(reset), .din(in_sck),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs (
    .clock(clock), .reset(reset), .din(in_cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_mosi (
    .clock(clock), .reset(reset), .din(in_mosi),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = &{1'b0, sck_level, cs_level, mosi_rise, mosi_fall};

  state_t           state_reg;
  logic [CW-1:0]    bit_cnt_reg;
  logic [WIDTH-1:0] tx_shift_reg;
  logic [WIDTH-1:0] rx_shift_reg;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full_reg;
  logic             load_pending_reg;
  logic             done_reg;
  logic             miso_reg;
  logic [WIDTH-1:0] rx_data_reg;
  logic             rx_valid_reg;
  logic             underrun_reg;

  logic             active;
  logic             last_bit;
  logic             load_now;
  logic [WIDTH-1:0] load_word;

  assign active    = (state_reg == ACTIVE);
  assign last_bit  = (bit_cnt_reg == CW'(WIDTH - 1));
  // A word load happens at CS fall, or on the SCK fall after a completed word.
  assign load_now  = (!active && cs_fall) ||
                     (active && !cs_rise && sck_fall && load_pending_reg);
  assign load_word = hold_full_reg ? hold_reg : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      bit_cnt_reg      <= '0;
      tx_shift_reg     <= '0;
      rx_shift_reg     <= '0;
      hold_reg         <= '0;
      hold_full_reg    <= 1'b0;
      load_pending_reg <= 1'b0;
      done_reg         <= 1'b0;
      miso_reg         <= 1'b0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      underrun_reg     <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      underrun_reg <= 1'b0;
      done_reg     <= 1'b0;

      if (done_reg) begin
        rx_data_reg  <= rx_shift_reg;
        rx_valid_reg <= 1'b1;
      end

      // A write coinciding with a load lands after the load sampled the old word.
      if (in_tx_valid && !hold_full_reg) begin
        hold_reg      <= in_tx_data;
        hold_full_reg <= 1'b1;
      end else if (load_now) begin
        hold_full_reg <= 1'b0;
      end

      if (load_now) begin
        tx_shift_reg     <= load_word;
        miso_reg         <= load_word[WIDTH-1];
        bit_cnt_reg      <= '0;
        underrun_reg     <= !hold_full_reg;
        load_pending_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (cs_fall) state_reg <= ACTIVE;
        end
        ACTIVE: begin
          if (sck_rise) begin
            rx_shift_reg <= {rx_shift_reg[WIDTH-2:0], mosi_level};
            if (last_bit) begin
              bit_cnt_reg      <= '0;
              done_reg         <= 1'b1;
              load_pending_reg <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else if (sck_fall && !load_pending_reg) begin
            tx_shift_reg <= tx_shift_reg << 1;
            miso_reg     <= tx_shift_reg[WIDTH-2];
          end
          // A word completed in this very cycle still reports via done_reg.
          if (cs_rise) begin
            state_reg        <= IDLE;
            bit_cnt_reg      <= '0;
            load_pending_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_miso     = miso_reg;
  assign out_miso_oe  = active;
  assign out_busy     = active;
  assign out_rx_data  = rx_data_reg;
  assign out_rx_valid = rx_valid_reg;
  assign out_tx_ready = !hold_full_reg;
  assign out_underrun = underrun_reg;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a mode-0 controller at clock/8 with
// hand-computed MISO/MOSI words and immediate-assertion checks.
module tb_spi_target;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_sck;
  logic       in_cs_n;
  logic       in_mosi;
  logic       out_miso;
  logic       out_miso_oe;
  logic [7:0] out_rx_data;
  logic       out_rx_valid;
  logic [7:0] in_tx_data;
  logic       in_tx_valid;
  logic       out_tx_ready;
  logic       out_underrun;
  logic       out_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rx_count = 0;
  int ur_count = 0;
  int rx_cyc   = 0;
  int last_rise_cyc = 0;
  logic [7:0] got;

  spi_target dut (
    .clock(clock), .reset(reset),
    .in_sck(in_sck), .in_cs_n(in_cs_n), .in_mosi(in_mosi),
    .out_miso(out_miso), .out_miso_oe(out_miso_oe),
    .out_rx_data(out_rx_data), .out_rx_valid(out_rx_valid),
    .in_tx_data(in_tx_data), .in_tx_valid(in_tx_valid),
    .out_tx_ready(out_tx_ready), .out_underrun(out_underrun),
    .out_busy(out_busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (out_rx_valid === 1'b1) begin
      rx_count = rx_count + 1;
      rx_cyc   = cyc;
    end
    if (out_underrun === 1'b1) ur_count = ur_count + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-18s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic write_tx(input logic [7:0] d);
    in_tx_data  = d;
    in_tx_valid = 1'b1;
    tick(1);
    in_tx_valid = 1'b0;
  endtask

  task automatic cs_start();
    in_cs_n = 1'b0;
    tick(5);
  endtask

  task automatic cs_end();
    in_cs_n = 1'b1;
    tick(6);
  endtask

  // Controller side of one word: MISO is sampled just before each SCK rise.
  task automatic send_word(input logic [7:0] w, input int nbits, input bit cs_last,
                           output logic [7:0] miso_bits);
    miso_bits = '0;
    in_mosi   = w[7];
    tick(1);
    for (int i = 0; i < nbits; i++) begin
      miso_bits[7-i] = out_miso;
      if (i == nbits - 1) last_rise_cyc = cyc;
      in_sck = 1'b1;
      if (cs_last && i == nbits - 1) in_cs_n = 1'b1;
      tick(4);
      in_sck = 1'b0;
      if (i < 7) in_mosi = w[6-i];
      tick(4);
    end
  endtask

  initial begin
    reset       = 1'b1;
    in_sck      = 1'b0;
    in_cs_n     = 1'b1;
    in_mosi     = 1'b0;
    in_tx_data  = 8'h00;
    in_tx_valid = 1'b0;
    tick(3);
    check("rst_miso",     {31'd0, out_miso},     32'd0);
    check("rst_miso_oe",  {31'd0, out_miso_oe},  32'd0);
    check("rst_rx_data",  {24'd0, out_rx_data},  32'd0);
    check("rst_rx_valid", {31'd0, out_rx_valid}, 32'd0);
    check("rst_tx_ready", {31'd0, out_tx_ready}, 32'd1);
    check("rst_underrun", {31'd0, out_underrun}, 32'd0);
    check("rst_busy",     {31'd0, out_busy},     32'd0);
    reset = 1'b0;
    tick(5);
    check("idle_busy",    {31'd0, out_busy},     32'd0);

    // Single word: tx A5, controller sends 3C
    write_tx(8'hA5);
    check("t1_tx_ready",  {31'd0, out_tx_ready}, 32'd0);
    cs_start();
    check("t1_busy",      {31'd0, out_busy},     32'd1);
    check("t1_miso_oe",   {31'd0, out_miso_oe},  32'd1);
    check("t1_tx_ready2", {31'd0, out_tx_ready}, 32'd1);
    rx_count = 0;
    send_word(8'h3C, 8, 1'b0, got);
    check("t1_miso_word", {24'd0, got},          32'hA5);
    check("t1_rx_data",   {24'd0, out_rx_data},  32'h3C);
    check("t1_rx_pulses", rx_count,              32'd1);
    check("t1_latency",   rx_cyc - last_rise_cyc, 32'd5);
    cs_end();
    check("t1_busy_end",  {31'd0, out_busy},     32'd0);
    check("t1_oe_end",    {31'd0, out_miso_oe},  32'd0);

    // Three back-to-back words with refill after every load
    write_tx(8'h11);
    rx_count = 0;
    ur_count = 0;
    cs_start();
    write_tx(8'h22);
    send_word(8'hC1, 8, 1'b0, got);
    check("t2_miso_w0",   {24'd0, got},          32'h11);
    check("t2_rx_w0",     {24'd0, out_rx_data},  32'hC1);
    write_tx(8'h33);
    send_word(8'h5A, 8, 1'b0, got);
    check("t2_miso_w1",   {24'd0, got},          32'h22);
    check("t2_rx_w1",     {24'd0, out_rx_data},  32'h5A);
    write_tx(8'h44);
    send_word(8'h96, 8, 1'b0, got);
    check("t2_miso_w2",   {24'd0, got},          32'h33);
    check("t2_rx_w2",     {24'd0, out_rx_data},  32'h96);
    check("t2_rx_pulses", rx_count,              32'd3);
    check("t2_underruns", ur_count,              32'd0);
    cs_end();

    // Underrun: CS falls with the holding register empty
    ur_count = 0;
    rx_count = 0;
    check("t3_tx_ready",  {31'd0, out_tx_ready}, 32'd1);
    cs_start();
    check("t3_underrun",  ur_count,              32'd1);
    write_tx(8'h55);
    send_word(8'hE7, 8, 1'b0, got);
    check("t3_miso_word", {24'd0, got},          32'h00);
    check("t3_rx_data",   {24'd0, out_rx_data},  32'hE7);
    check("t3_rx_pulses", rx_count,              32'd1);
    check("t3_underrun2", ur_count,              32'd1);
    cs_end();

    // Partial word: CS released after 5 bits
    write_tx(8'h9F);
    rx_count = 0;
    cs_start();
    send_word(8'h81, 5, 1'b0, got);
    cs_end();
    check("t4_rx_pulses", rx_count,              32'd0);
    check("t4_rx_data",   {24'd0, out_rx_data},  32'hE7);
    check("t4_busy",      {31'd0, out_busy},     32'd0);
    write_tx(8'h6B);
    cs_start();
    send_word(8'h2D, 8, 1'b0, got);
    check("t4_miso_next", {24'd0, got},          32'h6B);
    check("t4_rx_next",   {24'd0, out_rx_data},  32'h2D);
    cs_end();

    // Reset pulsed mid-word
    write_tx(8'hF0);
    cs_start();
    send_word(8'hC3, 3, 1'b0, got);
    write_tx(8'h12);
    reset   = 1'b1;
    in_cs_n = 1'b1;
    in_sck  = 1'b0;
    tick(1);
    check("t5_tx_ready",  {31'd0, out_tx_ready}, 32'd1);
    check("t5_busy",      {31'd0, out_busy},     32'd0);
    check("t5_miso_oe",   {31'd0, out_miso_oe},  32'd0);
    check("t5_miso",      {31'd0, out_miso},     32'd0);
    check("t5_rx_data",   {24'd0, out_rx_data},  32'd0);
    reset = 1'b0;
    tick(6);
    check("t5_no_start",  {31'd0, out_busy},     32'd0);
    write_tx(8'h3C);
    rx_count = 0;
    cs_start();
    send_word(8'hA5, 8, 1'b0, got);
    check("t5_miso_word", {24'd0, got},          32'h3C);
    check("t5_rx_data2",  {24'd0, out_rx_data},  32'hA5);
    check("t5_rx_pulses", rx_count,              32'd1);
    cs_end();

    // CS rise coincident with the 8th SCK rise
    write_tx(8'h77);
    rx_count = 0;
    cs_start();
    send_word(8'h4B, 8, 1'b1, got);
    tick(6);
    check("t6_rx_pulses", rx_count,              32'd1);
    check("t6_rx_data",   {24'd0, out_rx_data},  32'h4B);
    check("t6_busy",      {31'd0, out_busy},     32'd0);
    check("t6_miso_oe",   {31'd0, out_miso_oe},  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
